// File: rtl/rv32i_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_multicycle_ctrl
// Purpose  : Multi-cycle FSM controller for the RV32I core. Sequences
//            FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared datapath and a
//            req/ready memory, with bus timeout, illegal-opcode trap and a
//            retire strobe.
// Options  : RETIRE_CNT_EN - adds the CNT_WIDTH-bit instret counter port.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
`ifdef RETIRE_CNT_EN
   ,
   parameter int CNT_WIDTH   = 32
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       func7,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_ctrl,
   output logic       reg_write,
   output logic [1:0] mem_to_reg,
   output logic       retire,
   output logic       trap,
   output logic [1:0] trap_cause
`ifdef RETIRE_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] instret
`endif
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_ALU_WB, S_MEM_ADR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_BR, S_JAL, S_TRAP
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                          ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                          ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8,
                          ALU_SLTU = 4'd9;

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   // Count value seen on the last allowed wait cycle; mem_ready then still wins.
   localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t          state_q, state_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [1:0]      cause_q, cause_d;
   logic            w_wait, w_expire;
   logic [3:0]      w_op_alu;

   // Waiting on memory in an access state, and the bus-timeout condition.
   always_comb begin
      w_wait   = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                 && !mem_ready;
      w_expire = (MEM_TIMEOUT != 0) && w_wait && (tmo_q == TO_LAST);
   end

   // ALU operation for R/I-type; func7 only distinguishes SUB (R only) and SRA.
   always_comb begin
      w_op_alu = ALU_ADD;
      case (func3)
         3'b000: w_op_alu = (func7 && (state_q == S_EXEC_R)) ? ALU_SUB : ALU_ADD;
         3'b001: w_op_alu = ALU_SLL;
         3'b010: w_op_alu = ALU_SLT;
         3'b011: w_op_alu = ALU_SLTU;
         3'b100: w_op_alu = ALU_XOR;
         3'b101: w_op_alu = func7 ? ALU_SRA : ALU_SRL;
         3'b110: w_op_alu = ALU_OR;
         default: w_op_alu = ALU_AND;
      endcase
   end

   // Next-state and control decode; all outputs forced low while in reset.
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      alu_ctrl   = ALU_ADD;
      reg_write  = 1'b0;
      mem_to_reg = 2'd0;
      retire     = 1'b0;
      trap       = 1'b0;
      trap_cause = cause_q;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (w_expire) begin
               state_d = S_TRAP;
               cause_d = 2'd2;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            case (opcode)
               7'b0110011: state_d = S_EXEC_R;
               7'b0010011: state_d = S_EXEC_I;
               7'b0000011,
               7'b0100011: state_d = S_MEM_ADR;
               7'b1100011: state_d = S_EXEC_BR;
               7'b1101111: state_d = S_JAL;
               7'b0110111: state_d = S_EXEC_LUI;
               default: begin
                  state_d = S_TRAP;
                  cause_d = 2'd1;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_ctrl = w_op_alu;
            state_d  = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_b = 2'd1;
            alu_ctrl  = w_op_alu;
            state_d   = S_ALU_WB;
         end
         S_EXEC_LUI: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM_ADR: begin
            alu_src_b = 2'd1;
            state_d   = (opcode == 7'b0000011) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end else if (w_expire) begin
               state_d = S_TRAP;
               cause_d = 2'd2;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'd1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (w_expire) begin
               state_d = S_TRAP;
               cause_d = 2'd2;
            end
         end
         S_EXEC_BR: begin
            alu_ctrl = ALU_SUB;
            if (func3 == 3'b000 || func3 == 3'b001) begin
               // BEQ taken on zero, BNE taken on !zero; target was formed in DECODE.
               pc_write = (func3 == 3'b000) ? zero : !zero;
               pc_src   = pc_write;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end else begin
               state_d = S_TRAP;
               cause_d = 2'd1;
            end
         end
         S_JAL: begin
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            reg_write  = 1'b1;
            mem_to_reg = 2'd2;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      if (!reset_n) begin
         mem_req    = 1'b0;
         mem_write  = 1'b0;
         adr_src    = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = 1'b0;
         alu_src_a  = 2'd0;
         alu_src_b  = 2'd0;
         alu_ctrl   = 4'd0;
         reg_write  = 1'b0;
         mem_to_reg = 2'd0;
         retire     = 1'b0;
         trap       = 1'b0;
         trap_cause = 2'd0;
      end
      // Wait counter restarts on every state change.
      tmo_d = (state_d != state_q) ? '0 : (w_wait ? tmo_q + 1'b1 : tmo_q);
   end

   // State, wait counter and sticky trap cause registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         tmo_q   <= '0;
         cause_q <= 2'd0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         cause_q <= cause_d;
      end
   end

`ifdef RETIRE_CNT_EN
   logic [CNT_WIDTH-1:0] instret_q;

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + 1'b1;
      end
   end

   assign instret = instret_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32i_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_multicycle_ctrl
// Purpose  : Self-checking bench for rv32i_multicycle_ctrl. Each instruction
//            is expanded into a queue of expected per-cycle control vectors
//            from its class and planned memory wait counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_multicycle_ctrl;
   localparam int TO = 4;

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                          XOR_ = 4'd4, SLT = 4'd5, SLL = 4'd6, SRL = 4'd7,
                          SRA = 4'd8, SLTU = 4'd9;

   localparam int C_R = 0, C_I = 1, C_LUI = 2, C_LD = 3, C_ST = 4,
                  C_BR = 5, C_JAL = 6, C_ILL = 7;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] func3 = '0;
   logic       func7 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, pc_src;
   logic [1:0] alu_src_a, alu_src_b, mem_to_reg, trap_cause;
   logic [3:0] alu_ctrl;
   logic       reg_write, retire, trap;
`ifdef RETIRE_CNT_EN
   logic [31:0] instret;
`endif

   always #5 clk = ~clk;

   rv32i_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .func3(func3),
      .func7(func7), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
      .trap(trap), .trap_cause(trap_cause)
`ifdef RETIRE_CNT_EN
      , .instret(instret)
`endif
   );

   typedef struct packed {
      logic       mreq, mwr, adr, irw, pcw, pcs;
      logic [1:0] sa, sb;
      logic [3:0] alu;
      logic       rw;
      logic [1:0] m2r;
      logic       ret, trp;
      logic [1:0] cause;
   } ov_t;

   typedef struct packed {
      ov_t  v;
      logic care_alu;
      logic rdy;
      logic z;
   } ent_t;

   ent_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] retired = '0;
   bit          trapped = 1'b0;
   string       cur_tag = "init";

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic ov_t observed();
      ov_t o;
      o = {mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, alu_src_a,
           alu_src_b, alu_ctrl, reg_write, mem_to_reg, retire, trap, trap_cause};
      return o;
   endfunction

   // Fields that only carry meaning when their qualifier is active are ignored otherwise.
   function automatic ov_t msk(input ov_t x, input ent_t e);
      ov_t r;
      r = x;
      if (!e.care_alu) begin r.sa = '0; r.sb = '0; r.alu = '0; end
      if (!e.v.mreq)   begin r.mwr = 1'b0; r.adr = 1'b0; end
      if (!e.v.pcw)    r.pcs = 1'b0;
      if (!e.v.rw)     r.m2r = '0;
      return r;
   endfunction

   function automatic logic [3:0] alu_exp(input logic [2:0] f3, input logic f7, input bit is_r);
      logic [3:0] tbl [8];
      tbl = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};
      if (f3 == 3'd0 && is_r && f7) return SUB;
      if (f3 == 3'd5 && f7)         return SRA;
      return tbl[f3];
   endfunction

   task automatic push(input ov_t v, input bit care, input bit rdy, input bit z);
      ent_t e;
      e.v = v; e.care_alu = care; e.rdy = rdy; e.z = z;
      q.push_back(e);
   endtask

   task automatic push_alu(input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] alu);
      ov_t v;
      v = '0; v.sa = sa; v.sb = sb; v.alu = alu;
      push(v, 1'b1, 1'($urandom), 1'($urandom));
   endtask

   task automatic push_trap(input logic [1:0] cause);
      ov_t v;
      v = '0; v.trp = 1'b1; v.cause = cause;
      repeat (3) push(v, 1'b0, 1'($urandom), 1'($urandom));
      trapped = 1'b1;
   endtask

   // Memory access: w wait cycles, then completion carrying 'done' strobes.
   task automatic mem_phase(input ov_t base, input ov_t done, input int w, output bit tmo);
      tmo = (w >= TO);
      for (int i = 0; i < ((w >= TO) ? TO : w); i++) push(base, 1'b0, 1'b0, 1'($urandom));
      if (!tmo) push(base | done, 1'b0, 1'b1, 1'($urandom));
   endtask

   task automatic gen(input int cls, input logic [2:0] f3, input logic f7,
                      input int wf, input int wm, input bit z);
      ov_t b, d;
      bit  tmo;
      logic [6:0] op;
      case (cls)
         C_R:   op = 7'b0110011;
         C_I:   op = 7'b0010011;
         C_LUI: op = 7'b0110111;
         C_LD:  op = 7'b0000011;
         C_ST:  op = 7'b0100011;
         C_BR:  op = 7'b1100011;
         C_JAL: op = 7'b1101111;
         default: begin
            op = 7'h7F;
            if (f7) begin
               do op = 7'($urandom);
               while (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011,
                                 7'b0100011, 7'b1100011, 7'b1101111});
            end
         end
      endcase
      opcode = op; func3 = f3; func7 = f7;
      cur_tag = $sformatf("cls%0d_op%02h_f3%0d_f7%0d", cls, op, f3, f7);
      b = '0; b.mreq = 1'b1;
      d = '0; d.irw = 1'b1; d.pcw = 1'b1;
      mem_phase(b, d, wf, tmo);
      if (tmo) begin push_trap(2'd2); return; end
      push_alu(2'd1, 2'd1, ADD);
      b = '0;
      case (cls)
         C_R, C_I, C_LUI: begin
            if (cls == C_LUI) push_alu(2'd2, 2'd1, ADD);
            else push_alu(2'd0, (cls == C_I) ? 2'd1 : 2'd0, alu_exp(f3, f7, cls == C_R));
            b.rw = 1'b1; b.ret = 1'b1; b.m2r = 2'd0;
            push(b, 1'b0, 1'($urandom), 1'($urandom));
         end
         C_LD, C_ST: begin
            push_alu(2'd0, 2'd1, ADD);
            b.mreq = 1'b1; b.adr = 1'b1; b.mwr = (cls == C_ST);
            d = '0; d.ret = (cls == C_ST);
            mem_phase(b, d, wm, tmo);
            if (tmo) begin push_trap(2'd2); return; end
            if (cls == C_LD) begin
               b = '0; b.rw = 1'b1; b.m2r = 2'd1; b.ret = 1'b1;
               push(b, 1'b0, 1'($urandom), 1'($urandom));
            end
         end
         C_BR: begin
            b.alu = SUB;
            if (f3 > 3'd1) begin
               push(b, 1'b1, 1'($urandom), z);
               push_trap(2'd1);
            end else begin
               b.pcw = (f3 == 3'd0) ? z : !z; b.pcs = b.pcw; b.ret = 1'b1;
               push(b, 1'b1, 1'($urandom), z);
            end
         end
         C_JAL: begin
            b.pcw = 1'b1; b.pcs = 1'b1; b.rw = 1'b1; b.m2r = 2'd2; b.ret = 1'b1;
            push(b, 1'b0, 1'($urandom), 1'($urandom));
         end
         default: push_trap(2'd1);
      endcase
   endtask

   // Play up to n queued cycles: drive after posedge, compare on negedge.
   task automatic run(input int n);
      ent_t e;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         e = q.pop_front();
         mem_ready = e.rdy; zero = e.z;
         @(negedge clk);
         check(cur_tag, 32'(msk(observed(), e)), 32'(msk(e.v, e)));
`ifdef RETIRE_CNT_EN
         check("instret", instret, retired);
`endif
         if (e.v.ret) retired++;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      mem_ready = 1'($urandom);
      @(posedge clk); #1;
      retired = '0;
      repeat (2) begin
         @(negedge clk);
         check("reset_outputs", 32'(observed()), 32'd0);
`ifdef RETIRE_CNT_EN
         check("reset_instret", instret, 32'd0);
`endif
         @(posedge clk); #1;
      end
      reset_n = 1'b1;
      q.delete();
      trapped = 1'b0;
   endtask

   task automatic one(input int cls, input logic [2:0] f3, input logic f7,
                      input int wf, input int wm, input bit z);
      gen(cls, f3, f7, wf, wm, z);
      run(1000);
      if (trapped) do_reset();
   endtask

   initial begin
      int cls, wf, wm, r;
      logic [2:0] f3;
      do_reset();
      // Directed cases: add/sub/srai/srli, lw with 3 waits, beq both ways.
      one(C_R, 3'd0, 1'b0, 0, 0, 0);
      one(C_R, 3'd0, 1'b1, 0, 0, 0);
      one(C_I, 3'd5, 1'b1, 0, 0, 0);
      one(C_I, 3'd5, 1'b0, 0, 0, 0);
      one(C_I, 3'd0, 1'b1, 0, 0, 0);
      one(C_LD, 3'd2, 1'b0, 0, 3, 0);
      one(C_ST, 3'd2, 1'b0, 1, TO - 1, 0);
      one(C_BR, 3'd0, 1'b0, 0, 0, 1);
      one(C_BR, 3'd0, 1'b0, 0, 0, 0);
      one(C_BR, 3'd1, 1'b0, 0, 0, 0);
      one(C_JAL, 3'd0, 1'b0, 0, 0, 0);
      one(C_LUI, 3'd0, 1'b0, 0, 0, 0);
      one(C_ILL, 3'd0, 1'b0, 0, 0, 0);
      one(C_R, 3'd0, 1'b0, TO - 1, 0, 0);
      one(C_R, 3'd0, 1'b0, TO, 0, 0);
      one(C_LD, 3'd0, 1'b0, 0, TO, 0);
      one(C_BR, 3'd4, 1'b0, 0, 0, 1);
      repeat (3) one(C_R, 3'd0, 1'b0, 0, 0, 0);
`ifdef RETIRE_CNT_EN
      @(negedge clk);
      check("instret_after_adds", instret, 32'd3);
      @(posedge clk); #1;
`endif
      // Reset in the middle of a load: request drops, no write-back.
      gen(C_LD, 3'd2, 1'b0, 0, 3, 0);
      run(5);
      do_reset();
      // Randomized instruction stream.
      for (int n = 0; n < 200; n++) begin
         cls = $urandom_range(0, 8);
         if (cls == 8) cls = $urandom_range(0, 6);
         r = $urandom_range(0, 19);
         wf = (r < 12) ? 0 : (r < 19) ? $urandom_range(1, TO - 1) : TO;
         r = $urandom_range(0, 19);
         wm = (r < 10) ? 0 : (r < 19) ? $urandom_range(1, TO - 1) : TO;
         f3 = 3'($urandom);
         if (cls == C_BR && $urandom_range(0, 9) != 0) f3 = 3'($urandom_range(0, 1));
         one(cls, f3, 1'($urandom), wf, wm, 1'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
